// File: rtl/h_tree_capture_misr.sv
// Capture stage for the H-tree test-load logic cloud: registers qualified cloud
// outputs, compacts them into a MISR and hands the final signature over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; last run's signature and count remain visible
// CAPTURE | absorbing cap_in on cap_valid cycles until target captures are counted
// DONE    | final signature presented; waits for sig_ready
module h_tree_capture_misr #(
    parameter int DATA_W = 6,
    parameter int SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY = 16'h1021,
    parameter logic [SIG_W-1:0] SEED = 16'hFFFF,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_caps,
    input  logic             cap_valid,
    input  logic [DATA_W-1:0] cap_in,
    output logic             busy,
    output logic [CNT_W-1:0] cap_count,
    output logic [SIG_W-1:0] sig_out,
    output logic             sig_valid,
    input  logic             sig_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             sig_valid_q;
    logic [SIG_W-1:0] misr_next;

    assign misr_next = {sig_q[SIG_W-2:0], 1'b0}
                     ^ (sig_q[SIG_W-1] ? POLY : '0)
                     ^ {{(SIG_W-DATA_W){1'b0}}, cap_in};

    always_comb begin
        state_d  = state_q;
        sig_d    = sig_q;
        count_d  = count_q;
        target_d = target_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d   = SEED;
                    count_d = '0;
                    if (num_caps != '0) begin
                        target_d = num_caps;
                        state_d  = CAPTURE;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CAPTURE: begin
                if (cap_valid) begin
                    sig_d   = misr_next;
                    count_d = count_q + 1'b1;
                    if (count_q == target_q - 1'b1)
                        state_d = DONE;
                end
            end
            DONE: begin
                if (sig_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sig_q       <= SEED;
            count_q     <= '0;
            target_q    <= '0;
            sig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sig_q       <= sig_d;
            count_q     <= count_d;
            target_q    <= target_d;
            sig_valid_q <= (state_d == DONE);
        end
    end

    assign busy      = (state_q != IDLE);
    assign cap_count = count_q;
    assign sig_out   = sig_q;
    assign sig_valid = sig_valid_q;

endmodule

// File: doc/h_tree_capture_misr.md
Name: h_tree_capture_misr

Overview:
- Downstream capture stage for the 8-input / 6-output standard-cell logic cloud used as the H-tree clock-distribution test load.
- Registers the cloud's six outputs on qualified cycles and compacts them into a multiple-input signature register (MISR).
- Runs for a programmed number of captures, then presents the final signature on a valid/ready handshake.
- The bench or host compares that one word against a golden signature instead of tracing every cloud output.

Parameters:
- DATA_W, 6, width of captured cloud output vector.
- SIG_W, 16, MISR width; must be greater than DATA_W.
- POLY, 16'h1021, MISR feedback polynomial, XORed in when the shifted-out MSB is 1.
- SEED, 16'hFFFF, MISR value loaded on start and on reset.
- CNT_W, 16, width of capture counters.

Ports:
- clk  input  1  single clock for all state.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a capture run.
- num_caps  input  CNT_W  number of captures in the run; sampled on accepted start.
- cap_valid  input  1  cap_in carries a valid cloud result this cycle.
- cap_in  input  DATA_W  cloud outputs packed {y,z,p,q,r,s}, y at MSB.
- busy  output  1  high while in CAPTURE or DONE.
- cap_count  output  CNT_W  captures absorbed in the current or last run.
- sig_out  output  SIG_W  current MISR contents.
- sig_valid  output  1  final signature available.
- sig_ready  input  1  consumer accepts the signature.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE, busy=0, sig_valid=0, cap_count=0, sig_out=SEED, latched target=0.
- FSM states IDLE, CAPTURE, DONE:
  - IDLE, start=1, num_caps!=0: sig<=SEED, cap_count<=0, target<=num_caps, go to CAPTURE.
  - IDLE, start=1, num_caps==0: sig<=SEED, cap_count<=0, go straight to DONE. sig_valid=1 the cycle after start.
  - CAPTURE, cap_valid=1: sig<=misr(sig,cap_in), cap_count<=cap_count+1.
    - If cap_count==target-1 on that edge, go to DONE. sig_valid=1 from the next cycle.
  - CAPTURE, cap_valid=0: hold all state. Gaps of any length are legal.
  - DONE: sig_valid=1; sig_out and cap_count held stable. cap_valid is ignored.
    - sig_valid & sig_ready on an edge: go to IDLE, sig_valid=0 after the edge.
- MISR update (combinational next-state, SIG_W bits):
  - next = (sig<<1) XOR (sig[SIG_W-1] ? POLY : 0) XOR zero_extend(cap_in).
- Latency: the first capture edge is the one after the start edge. Final sig_valid rises one cycle after the last counted capture.
- start while busy: ignored; no reload or counter change.
- start and sig_ready handshake on the same edge in DONE: the handshake completes and start is ignored. start is only accepted in IDLE.
- In IDLE: sig_out and cap_count keep the last run's values until the next accepted start.
- cap_count never wraps within a run, because target ≤ 2^CNT_W-1.
- sig_ready while sig_valid=0: no effect.
- busy is combinational from state (IDLE → 0).
- Reset asserted mid-run: immediately return to reset values. A partial signature is never presented.
- No combinational path from cap_in or cap_valid to any output. All outputs are registered except busy, which decodes registered state.

Test Plan:
- Reset, then start with num_caps=2; cap_in=6'h00, then 6'h3F with cap_valid=1 on consecutive cycles.
  -> sig_out=16'hEFDF after the first capture; sig_valid=1 with sig_out=16'hCFA0 and cap_count=2 one cycle after the second.
- Same run with cap_valid low for 3 cycles between the two captures.
  -> identical final signature 16'hCFA0; busy=1 throughout the gap.
- start with num_caps=0.
  -> next cycle sig_valid=1, sig_out=16'hFFFF, cap_count=0.
- Run ends with sig_ready held 0 for 5 cycles, then pulsed 1.
  -> sig_valid and sig_out stable all 5 cycles; IDLE and sig_valid=0 the cycle after the pulse.
- start pulsed during CAPTURE after 1 of 2 captures, and cap_valid=1 in DONE.
  -> no reload, cap_count ends at 2, final signature unchanged (16'hCFA0).
- Assert rst_n=0 asynchronously mid-CAPTURE.
  -> outputs go to reset values before the next clk edge; a new start/run after reset produces 16'hCFA0 again.
